// File: rtl/cdda_pkg.sv
// cdda_pkg: constants and types shared by the CDDA sample path.
// Sector geometry, FIFO request threshold shared with the FIFO,
// and the sector feeder state encoding.
package cdda_pkg;

   // One CDDA audio sector: 2352 bytes, i.e. 588 stereo 16-bit sample pairs.
   localparam int CDDA_SECTOR_BYTES = 2352;
   localparam int CDDA_SECTOR_WORDS = CDDA_SECTOR_BYTES / 2;

   // Width of a counter that indexes words within one sector.
   localparam int CDDA_WORD_CNT_W = $clog2(CDDA_SECTOR_WORDS);

   // FIFO geometry. The FIFO raises cdda_req while at least one full sector
   // of space is free, so a sector, once started, always fits.
   localparam int CDDA_FIFO_DEPTH_WORDS   = 4096;
   localparam int CDDA_FIFO_REQ_THRESHOLD = CDDA_FIFO_DEPTH_WORDS - CDDA_SECTOR_WORDS;

   // Sector feeder FSM. Explicit encodings keep the values stable for
   // anything that decodes the state from a debug register.
   typedef enum logic [2:0] {
      FEED_IDLE  = 3'd0,
      FEED_ARM   = 3'd1,
      FEED_READ  = 3'd2,
      FEED_WRITE = 3'd3,
      FEED_NEXT  = 3'd4
   } feed_state_e;

endpackage

// File: rtl/cdda_sector_feeder_if.sv
// cdda_sector_feeder_if: memory read port and FIFO write port of the
// CDDA sector feeder. The master side is the feeder; the slave side is
// the memory arbiter plus the CDDA FIFO.
interface cdda_sector_feeder_if #(
   parameter int ADDR_W = 24
) ();

   // FIFO write side
   logic              clk_en;     // FIFO write-side clock enable
   logic              cdda_req;   // FIFO has room for a full sector
   logic              cdda_wr;    // write strobe, held until a clk_en cycle
   logic [15:0]       cdda_data;  // raw memory word, FIFO does the byte swap

   // Memory read side
   logic              mem_req;    // held until mem_ack
   logic [ADDR_W-1:0] mem_addr;   // word address
   logic              mem_ack;    // one-cycle pulse, data valid in same cycle
   logic [15:0]       mem_rdata;

   modport master (
      input  clk_en, cdda_req, mem_ack, mem_rdata,
      output cdda_wr, cdda_data, mem_req, mem_addr
   );

   modport slave (
      output clk_en, cdda_req, mem_ack, mem_rdata,
      input  cdda_wr, cdda_data, mem_req, mem_addr
   );

endinterface

// File: rtl/cdda_sector_feeder.sv
// cdda_sector_feeder: streams whole 1176-word CDDA sectors from memory
// into the CDDA FIFO, one sector per FIFO room request.
// Optional build macro CDDA_FEEDER_LOOP_EN: when the programmed sector
// count runs out while play is still high, reload the captured start
// address and count and repeat seamlessly instead of stopping.
module cdda_sector_feeder
   import cdda_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int CNT_W  = 18
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              play,
   input  logic              pause,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [CNT_W-1:0]  sector_count,
   cdda_sector_feeder_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  sectors_left
);

   localparam logic [CDDA_WORD_CNT_W-1:0] WORD_LAST =
      CDDA_WORD_CNT_W'(CDDA_SECTOR_WORDS - 1);

   feed_state_e                state;
   logic                       play_q;
   logic                       play_rise;
   logic [ADDR_W-1:0]          addr;
   logic [CDDA_WORD_CNT_W-1:0] word_cnt;

`ifdef CDDA_FEEDER_LOOP_EN
   // Start parameters captured on the play edge, reused on every repeat.
   logic [ADDR_W-1:0]          loop_addr;
   logic [CNT_W-1:0]           loop_count;
`endif

   assign play_rise = play & ~play_q;

   // Play edge detector. It keeps tracking play through reset so that a
   // play level held across reset is not mistaken for a fresh start.
   always_ff @(posedge clk_sys) begin
      play_q <= play;
   end

`ifdef CDDA_FEEDER_LOOP_EN
   // Capture the start parameters used for seamless repeat.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         loop_addr  <= '0;
         loop_count <= '0;
      end else if (state == FEED_IDLE && play_rise) begin
         loop_addr  <= start_addr;
         loop_count <= sector_count;
      end
   end
`endif

   // Sector engine: arm on a FIFO request, then move every word of the
   // sector (read, then write) without looking at play, pause or cdda_req.
   always_ff @(posedge clk_sys) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge value of every other one, whatever the statement order.
      if (reset) begin
         state         <= FEED_IDLE;
         addr          <= '0;
         word_cnt      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         sectors_left  <= '0;
         bus.cdda_wr   <= 1'b0;
         bus.cdda_data <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_addr  <= '0;
      end else begin
         done <= 1'b0;

         case (state)
            FEED_IDLE: begin
               // A play edge while busy cannot reach here: the edge is
               // only looked at in IDLE.
               if (play_rise) begin
                  addr         <= start_addr;
                  sectors_left <= sector_count;
                  busy         <= 1'b1;
                  state        <= FEED_ARM;
               end
            end

            FEED_ARM: begin
               if (sectors_left == '0) begin
                  done <= 1'b1;
`ifdef CDDA_FEEDER_LOOP_EN
                  if (play) begin
                     addr         <= loop_addr;
                     sectors_left <= loop_count;
                  end else begin
                     busy  <= 1'b0;
                     state <= FEED_IDLE;
                  end
`else
                  busy  <= 1'b0;
                  state <= FEED_IDLE;
`endif
               end else if (!play) begin
                  busy  <= 1'b0;
                  state <= FEED_IDLE;
               end else if (!pause && bus.cdda_req) begin
                  sectors_left <= sectors_left - 1'b1;
                  word_cnt     <= '0;
                  bus.mem_req  <= 1'b1;
                  bus.mem_addr <= addr;
                  state        <= FEED_READ;
               end
            end

            FEED_READ: begin
               if (bus.mem_ack) begin
                  bus.mem_req   <= 1'b0;
                  bus.cdda_data <= bus.mem_rdata;
                  bus.cdda_wr   <= 1'b1;
                  state         <= FEED_WRITE;
               end
            end

            FEED_WRITE: begin
               // cdda_data stays put until the FIFO takes the word.
               if (bus.clk_en) begin
                  bus.cdda_wr <= 1'b0;
                  addr        <= addr + 1'b1;
                  word_cnt    <= word_cnt + 1'b1;
                  if (word_cnt == WORD_LAST) begin
                     state <= FEED_NEXT;
                  end else begin
                     bus.mem_req  <= 1'b1;
                     bus.mem_addr <= addr + 1'b1;
                     state        <= FEED_READ;
                  end
               end
            end

            FEED_NEXT: begin
               state <= FEED_ARM;
            end

            default: begin
               state <= FEED_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cdda_sector_feeder.sv
// tb_cdda_sector_feeder: self-checking bench for cdda_sector_feeder.
// The expected FIFO stream is built from the start address and sector
// count alone; a memory model answers reads with an address-derived word.
module tb_cdda_sector_feeder;

   localparam int ADDR_W = 24;
   localparam int CNT_W  = 18;
   localparam int SECW   = 1176;   // 16-bit words per 2352-byte sector

   logic              clk_sys = 1'b0;
   logic              reset   = 1'b1;
   logic              play    = 1'b0;
   logic              pause   = 1'b0;
   logic [ADDR_W-1:0] start_addr   = '0;
   logic [CNT_W-1:0]  sector_count = '0;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  sectors_left;

   cdda_sector_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   cdda_sector_feeder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .play         (play),
      .pause        (pause),
      .start_addr   (start_addr),
      .sector_count (sector_count),
      .bus          (bus),
      .busy         (busy),
      .done         (done),
      .sectors_left (sectors_left)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Memory contents: a fixed function of the word address.
   function automatic logic [15:0] mem_word(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ {8'h5A, a[23:16]};
   endfunction

   // ---------------- environment: memory, clk_en, monitor ----------------
   int          ce_mode   = 0;   // 0: always, 1: one cycle in four, 2: random
   int          wait_mode = 0;   // 0: zero-wait, 1: one wait, 2: random 0..2
   int          wait_left = 0;
   int          cyc       = 0;
   logic        env_ce    = 1'b1;
   logic [15:0] got_q[$];
   int          done_at[$];
   int          done_cnt    = 0;
   int          memreq_cyc  = 0;
   int          viol_both   = 0;
   int          viol_stable = 0;
   int          viol_done   = 0;
   logic        prev_hold   = 1'b0;
   logic        prev_done   = 1'b0;
   logic [15:0] prev_data   = '0;
   logic        clr_tog     = 1'b0;
   logic        clr_seen    = 1'b0;

   function automatic int next_wait();
      case (wait_mode)
         0:       return 0;
         1:       return 1;
         default: return int'($urandom_range(0, 2));
      endcase
   endfunction

   // Inputs change and outputs are sampled on the falling edge.
   always @(negedge clk_sys) begin
      cyc = cyc + 1;
      if (clr_tog != clr_seen) begin
         clr_seen = clr_tog;
         got_q.delete();
         done_at.delete();
         done_cnt   = 0;
         memreq_cyc = 0;
      end
      case (ce_mode)
         0:       env_ce = 1'b1;
         1:       env_ce = (cyc % 4 == 0);
         default: env_ce = ($urandom_range(0, 1) == 1);
      endcase
      bus.clk_en = env_ce;
      if (bus.mem_req) begin
         if (wait_left > 0) begin
            wait_left--;
            bus.mem_ack = 1'b0;
         end else begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_word(bus.mem_addr);
            wait_left     = next_wait();
         end
      end else begin
         bus.mem_ack = 1'b0;
      end
      if (!reset) begin
         if (bus.cdda_wr && bus.mem_req) viol_both++;
         if (bus.cdda_wr && prev_hold && bus.cdda_data != prev_data) viol_stable++;
         if (bus.cdda_wr && env_ce) got_q.push_back(bus.cdda_data);
         if (done) begin
            done_cnt++;
            done_at.push_back(got_q.size());
            if (prev_done) viol_done++;
         end
         if (bus.mem_req) memreq_cyc++;
      end
      prev_hold = bus.cdda_wr && !env_ce;
      prev_data = bus.cdda_data;
      prev_done = done;
   end

   // ---------------- reference model and helpers ----------------
   logic [15:0] exp_q[$];

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic clear_sb();
      clr_tog = ~clr_tog;
      tick(2);
      exp_q.delete();
   endtask

   // Expected FIFO stream: count whole sectors of consecutive words,
   // addresses wrapping at 2^ADDR_W.
   task automatic build_exp(input logic [ADDR_W-1:0] s, input int count);
      for (int k = 0; k < count * SECW; k++) exp_q.push_back(mem_word(s + ADDR_W'(k)));
   endtask

   function automatic int exp_left_after(input int count);
`ifdef CDDA_FEEDER_LOOP_EN
      return count;
`else
      return 0;
`endif
   endfunction

   function automatic int exp_dones(input int count);
`ifdef CDDA_FEEDER_LOOP_EN
      return (count == 0) ? 2 : 1;
`else
      return 1;
`endif
   endfunction

   task automatic wait_done(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sys);
         n++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_got(input int words, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sys);
         if (got_q.size() >= words) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_stream(input string tag);
      int n;
      int bad;
      check({tag, "_len"}, got_q.size(), exp_q.size());
      n   = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      bad = -1;
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i]) begin
            bad = i;
            break;
         end
      end
      if (bad >= 0) begin
         $display("  first differing word index %0d", bad);
         check({tag, "_data"}, got_q[bad], exp_q[bad]);
      end else if (n > 0) begin
         check({tag, "_data"}, got_q[n-1], exp_q[n-1]);
      end
   endtask

   task automatic start_play(input logic [ADDR_W-1:0] s, input int count);
      @(negedge clk_sys);
      start_addr   = s;
      sector_count = CNT_W'(count);
      play         = 1'b1;
   endtask

   typedef struct {
      logic [ADDR_W-1:0] start;
      int                count;
      int                ce;
      int                wt;
      int                exp_writes;
   } vec_t;

   task automatic run_vec(input string tag, input vec_t v, input bit chk_lat);
      bit ok;
      int n;
      int elapsed;
      ce_mode   = v.ce;
      wait_mode = v.wt;
      clear_sb();
      build_exp(v.start, v.count);
      bus.cdda_req = 1'b1;
      pause        = 1'b0;
      start_play(v.start, v.count);
      elapsed = 0;
      if (chk_lat) begin
         @(negedge clk_sys);
         elapsed++;
         check({tag, "_arm_busy"}, busy, 1);
         check({tag, "_arm_no_mreq"}, bus.mem_req, 0);
         @(negedge clk_sys);
         elapsed++;
         check({tag, "_read_mreq"}, bus.mem_req, 1);
         check({tag, "_read_addr"}, bus.mem_addr, v.start);
      end
      wait_done(v.count * SECW * 10 + 200, ok, n);
      elapsed += n;
      play = 1'b0;
      tick(6);
      check({tag, "_done_seen"}, ok, 1);
      check_stream(tag);
      check({tag, "_writes"}, got_q.size(), v.exp_writes);
      check({tag, "_done_cnt"}, done_cnt, exp_dones(v.count));
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_left_end"}, sectors_left, exp_left_after(v.count));
      check({tag, "_mreq_iff_data"}, memreq_cyc != 0, v.exp_writes != 0);
      if (chk_lat) check({tag, "_cycles_to_done"}, elapsed, 2 + v.count * (2 * SECW + 2));
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[5];

   initial begin
      bit ok, ok2;
      int n, mr0;
      logic [ADDR_W-1:0] s;

      vecs[0] = '{start: 24'h001000, count: 2, ce: 0, wt: 0, exp_writes: 2 * SECW};
      vecs[1] = '{start: 24'h002000, count: 1, ce: 1, wt: 0, exp_writes: SECW};
      vecs[2] = '{start: 24'hFFFF00, count: 1, ce: 2, wt: 2, exp_writes: SECW};
      vecs[3] = '{start: 24'h00ABCD, count: 0, ce: 0, wt: 0, exp_writes: 0};
      vecs[4] = '{start: 24'h123456, count: 1, ce: 0, wt: 1, exp_writes: SECW};

      bus.cdda_req = 1'b0;
      tick(3);
      check("rst_cdda_wr", bus.cdda_wr, 0);
      check("rst_cdda_data", bus.cdda_data, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_left", sectors_left, 0);
      reset = 1'b0;
      tick(2);

      // Table-driven playback runs.
      for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i], i == 0);

      // cdda_req low in ARM blocks reads; dropping it mid-sector does not.
      ce_mode = 0; wait_mode = 0;
      clear_sb();
      build_exp(24'h040000, 1);
      bus.cdda_req = 1'b0;
      start_play(24'h040000, 1);
      tick(500);
      check("req_low_no_mreq", memreq_cyc, 0);
      check("req_low_busy", busy, 1);
      check("req_low_left", sectors_left, 1);
      bus.cdda_req = 1'b1;
      wait_got(10, 200, ok);
      bus.cdda_req = 1'b0;
      check("req_reach_w10", ok, 1);
      wait_done(SECW * 4, ok, n);
      play = 1'b0;
      tick(4);
      check("req_done_seen", ok, 1);
      check_stream("req_drop");
      check("req_done_cnt", done_cnt, 1);

      // Pause mid-sector 1 of 3: sector finishes, then holds at the boundary.
      clear_sb();
      s = 24'h080000;
      build_exp(s, 3);
      bus.cdda_req = 1'b1;
      start_play(s, 3);
      wait_got(500, 3000, ok);
      pause = 1'b1;
      wait_got(SECW, 3000, ok2);
      check("pause_mid_reached", ok, 1);
      check("pause_sector_end", ok2, 1);
      tick(5);
      mr0 = memreq_cyc;
      tick(300);
      check("pause_no_mreq", memreq_cyc, mr0);
      check("pause_words", got_q.size(), SECW);
      check("pause_left", sectors_left, 2);
      check("pause_busy", busy, 1);
      pause = 1'b0;
      wait_done(SECW * 6, ok, n);
      play = 1'b0;
      tick(4);
      check("pause_done_seen", ok, 1);
      check_stream("pause_resume");

      // Reset in the middle of a sector, then restart from a new address.
      clear_sb();
      start_play(24'h003000, 2);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_sys);
         if (got_q.size() >= 600 && bus.cdda_wr) begin
            ok = 1'b1;
            break;
         end
      end
      check("rst_mid_reached", ok, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      check("rst_mid_cdda_wr", bus.cdda_wr, 0);
      check("rst_mid_cdda_data", bus.cdda_data, 0);
      check("rst_mid_mem_req", bus.mem_req, 0);
      check("rst_mid_mem_addr", bus.mem_addr, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_left", sectors_left, 0);
      tick(2);
      reset = 1'b0;
      tick(5);
      check("rst_play_level_no_start", busy, 0);
      play = 1'b0;
      tick(2);
      clear_sb();
      build_exp(24'h005000, 1);
      start_play(24'h005000, 1);
      wait_done(SECW * 4, ok, n);
      play = 1'b0;
      tick(4);
      check("restart_done_seen", ok, 1);
      check_stream("restart");

`ifdef CDDA_FEEDER_LOOP_EN
      // One-sector loop with play held: repeats from start_addr.
      clear_sb();
      build_exp(24'h007000, 1);
      build_exp(24'h007000, 1);
      start_play(24'h007000, 1);
      wait_done(SECW * 4, ok, n);
      wait_done(SECW * 4, ok2, n);
      play = 1'b0;
      tick(6);
      check("loop_done1", ok, 1);
      check("loop_done2", ok2, 1);
      check("loop_done_cnt", done_cnt, 2);
      check("loop_done_at0", (done_at.size() > 0) ? done_at[0] : -1, SECW);
      check("loop_done_at1", (done_at.size() > 1) ? done_at[1] : -1, 2 * SECW);
      check_stream("loop");
      check("loop_busy_end", busy, 0);
`else
      // One sector with play held: stops after a single done.
      clear_sb();
      build_exp(24'h007000, 1);
      start_play(24'h007000, 1);
      wait_done(SECW * 4, ok, n);
      tick(200);
      check("once_done_seen", ok, 1);
      check("once_done_cnt", done_cnt, 1);
      check("once_busy", busy, 0);
      check("once_left", sectors_left, 0);
      check_stream("once");
      play = 1'b0;
      tick(2);
`endif

      // Randomized runs against the stream model.
      for (int t = 0; t < 2; t++) begin
         vec_t v;
         v.start      = (t == 0) ? ADDR_W'(24'hFFFFFF - $urandom_range(0, SECW - 1))
                                 : ADDR_W'($urandom);
         v.count      = int'($urandom_range(0, 1)) + t;
         v.ce         = int'($urandom_range(0, 2));
         v.wt         = int'($urandom_range(0, 2));
         v.exp_writes = v.count * SECW;
         run_vec($sformatf("rnd%0d", t), v, 1'b0);
      end

      check("never_wr_and_req", viol_both, 0);
      check("data_stable_while_wr", viol_stable, 0);
      check("done_single_cycle", viol_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
